// File: rtl/pixel_weight_network.sv
// ============================================================================
// Module   : pixel_weight_network
// Purpose  : Single-neuron pulse-rate scorer of a HEIGHT-pixel binary input.
//            Optional macro BALANCE_CLAMP_EN clamps balance_out to [0, max].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_weight_network #(
    parameter int             WIDTH           = 8,
    parameter int             HEIGHT          = 7,
    parameter int             NUM_POS_WEIGHTS = 3,
    parameter logic [WIDTH:0] WEIGHTS [0:HEIGHT-1] = '{60, 60, 60, 260, 260, 260, 260},
    localparam int            B = $clog2(HEIGHT * (2**WIDTH - 1) + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HEIGHT-1:0] pixels,
    output logic              neuron_out,
    output logic [B-1:0]      balance_out,
    output logic              pixel_out_out,
    output logic              reset_out
);

    localparam int c_CNT_W   = WIDTH + 1;
    localparam int c_IDX_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int c_ACC_W   = B + 2;
    localparam int c_BAL_MAX = HEIGHT * (2**WIDTH - 1);

    if (NUM_POS_WEIGHTS > HEIGHT) begin : g_num_pos_check
        $error("NUM_POS_WEIGHTS exceeds HEIGHT");
    end

    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_IDX_W-1:0]        r_idx;
    logic [WIDTH-1:0]          r_acc_neg;
    logic [WIDTH-1:0]          r_acc_pos;
    logic                      r_carry_pos_d;
    logic [c_CNT_W-1:0]        r_win_cnt;
    logic signed [c_ACC_W-1:0] r_acc_f;

    logic                      w_reset_circuit;
    logic                      w_last;
    logic                      w_frame_end;
    logic                      w_stim;
    logic [WIDTH:0]            w_weight;
    logic                      w_sign;
    logic [WIDTH-1:0]          w_mag;
    logic                      w_fire;
    logic [WIDTH:0]            w_neg_sum;
    logic [WIDTH:0]            w_pos_sum;
    logic                      w_carry_neg;
    logic                      w_carry_pos;
    logic                      w_pixel_out;
    logic [c_CNT_W:0]          w_win_total;
    logic signed [c_ACC_W-1:0] w_win_delta;
    logic signed [c_ACC_W-1:0] w_acc_next;
    logic                      w_neuron;
    logic [B-1:0]              w_balance;

    assign w_reset_circuit = (r_cnt != '0);
    assign w_last          = &r_cnt;
    assign w_frame_end     = w_last && (r_idx == c_IDX_W'(HEIGHT - 1));
    assign w_stim          = w_reset_circuit & r_cnt[0];

    assign w_weight = WEIGHTS[r_idx];
    assign w_sign   = w_weight[WIDTH];
    assign w_mag    = w_weight[WIDTH-1:0];
    assign w_fire   = w_stim & pixels[r_idx];

    // Each divider overflows exactly w times across the window's odd-cnt pulses.
    assign w_neg_sum   = {1'b0, r_acc_neg} + {1'b0, w_mag};
    assign w_pos_sum   = {1'b0, r_acc_pos} + {1'b0, w_mag};
    assign w_carry_neg = w_fire &  w_sign & w_neg_sum[WIDTH];
    assign w_carry_pos = w_fire & ~w_sign & w_pos_sum[WIDTH];

    assign w_pixel_out = w_reset_circuit & ((w_stim & ~w_carry_neg) | r_carry_pos_d);

    // Window total includes the final cycle's pulse so the commit lands on the wrap edge.
    assign w_win_total = {1'b0, r_win_cnt} + {{c_CNT_W{1'b0}}, w_pixel_out};
    assign w_win_delta = $signed(c_ACC_W'(w_win_total)) - $signed(c_ACC_W'(2**WIDTH));
    assign w_acc_next  = r_acc_f + w_win_delta;
    assign w_neuron    = ~w_acc_next[c_ACC_W-1] & (w_acc_next != '0);

`ifdef BALANCE_CLAMP_EN
    always_comb begin
        w_balance = w_acc_next[B-1:0];
        if (w_acc_next[c_ACC_W-1]) begin
            w_balance = '0;
        end else if (w_acc_next > c_ACC_W'(c_BAL_MAX)) begin
            w_balance = B'(c_BAL_MAX);
        end
    end
`else
    assign w_balance = w_acc_next[B-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_idx <= (r_idx == c_IDX_W'(HEIGHT - 1)) ? '0 : r_idx + c_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_neg     <= '1;
            r_acc_pos     <= '1;
            r_carry_pos_d <= 1'b0;
        end else if (!w_reset_circuit) begin
            r_acc_neg     <= '1;
            r_acc_pos     <= '1;
            r_carry_pos_d <= 1'b0;
        end else begin
            if (w_fire && w_sign) begin
                r_acc_neg <= w_neg_sum[WIDTH-1:0];
            end
            if (w_fire && !w_sign) begin
                r_acc_pos <= w_pos_sum[WIDTH-1:0];
            end
            r_carry_pos_d <= w_carry_pos;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_cnt   <= '0;
            r_acc_f     <= '0;
            neuron_out  <= 1'b0;
            balance_out <= '0;
        end else if (w_last) begin
            r_win_cnt <= '0;
            if (w_frame_end) begin
                r_acc_f     <= '0;
                neuron_out  <= w_neuron;
                balance_out <= w_balance;
            end else begin
                r_acc_f <= w_acc_next;
            end
        end else if (w_pixel_out) begin
            r_win_cnt <= r_win_cnt + c_CNT_W'(1);
        end
    end

    assign pixel_out_out = w_pixel_out;
    assign reset_out     = w_reset_circuit;

endmodule

`default_nettype wire

// File: tb/tb_pixel_weight_network.sv
// ============================================================================
// Module   : tb_pixel_weight_network
// Purpose  : Directed self-checking bench for pixel_weight_network.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_weight_network;

`ifdef BALANCE_CLAMP_EN
    localparam int c_BAL_NEG4 = 0;
`else
    localparam int c_BAL_NEG4 = 2044;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  pix_a, pix_b;
    logic        neu_a, neu_b, po_a, po_b, ro_a, ro_b;
    logic [10:0] bal_a, bal_b;

    int   vectors     = 0;
    int   miscompares = 0;
    int   pa[7], pb[7], rl[7], bmis[7];
    int   ea[7], eb[7];
    logic r0[7];

    always #5 clk = ~clk;

    pixel_weight_network dut_a (
        .clk           (clk),
        .rst           (rst),
        .pixels        (pix_a),
        .neuron_out    (neu_a),
        .balance_out   (bal_a),
        .pixel_out_out (po_a),
        .reset_out     (ro_a)
    );

    pixel_weight_network #(
        .WEIGHTS ('{9'd255, 9'd255, 9'd60, 9'd260, 9'd260, 9'd260, 9'd260})
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .pixels        (pix_b),
        .neuron_out    (neu_b),
        .balance_out   (bal_b),
        .pixel_out_out (po_b),
        .reset_out     (ro_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Samples one 512-cycle window at negedges, starting at its cnt==0 cycle.
    task automatic run_window(input int w);
        pa[w] = 0; pb[w] = 0; rl[w] = 0; bmis[w] = 0; r0[w] = 1'b0;
        for (int i = 0; i < 512; i++) begin
            if (po_a === 1'b1) pa[w]++;
            if (po_b === 1'b1) pb[w]++;
            if (ro_a !== 1'b1) rl[w]++;
            if (i == 0) r0[w] = (ro_a === 1'b0) && (ro_b === 1'b0);
            if (po_b !== (i != 0)) bmis[w]++;
            @(negedge clk);
        end
    endtask

    task automatic run_frame();
        for (int w = 0; w < 7; w++) run_window(w);
    endtask

    task automatic check_frame(input string nm, input int bal_ea, input int neu_ea,
                               input int bal_eb, input int neu_eb);
        for (int w = 0; w < 7; w++) begin
            chk($sformatf("%s_a_pulses_w%0d", nm, w), pa[w], ea[w]);
            chk($sformatf("%s_b_pulses_w%0d", nm, w), pb[w], eb[w]);
            chk($sformatf("%s_reset_out_lows_w%0d", nm, w), rl[w], 1);
            chk($sformatf("%s_reset_out_at_wrap_w%0d", nm, w), {31'd0, r0[w]}, 1);
        end
        chk({nm, "_a_balance"}, {21'd0, bal_a}, bal_ea);
        chk({nm, "_a_neuron"},  {31'd0, neu_a}, neu_ea);
        chk({nm, "_b_balance"}, {21'd0, bal_b}, bal_eb);
        chk({nm, "_b_neuron"},  {31'd0, neu_b}, neu_eb);
    endtask

    initial begin
        rst   = 1'b0;
        pix_a = 7'd0;
        pix_b = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_a_neuron",    {31'd0, neu_a}, 0);
        chk("rst_a_balance",   {21'd0, bal_a}, 0);
        chk("rst_a_pixel_out", {31'd0, po_a},  0);
        chk("rst_a_reset_out", {31'd0, ro_a},  0);
        chk("rst_b_balance",   {21'd0, bal_b}, 0);
        rst = 1'b1;

        // Idle pixels on A; B has a strong positive and two weak negative pixels on.
        pix_b = 7'b0101010;
        ea = '{256, 256, 256, 256, 256, 256, 256};
        eb = '{256, 511, 256, 252, 256, 252, 256};
        run_frame();
        check_frame("f1", 0, 0, 247, 1);

        // Single negative pixel on A; single full-scale positive pixel on B.
        pix_a = 7'b0001000;
        pix_b = 7'b0000001;
        ea = '{256, 256, 256, 252, 256, 256, 256};
        eb = '{511, 256, 256, 256, 256, 256, 256};
        for (int w = 0; w < 4; w++) run_window(w);
        chk("f2_b_balance_hold", {21'd0, bal_b}, 247);
        chk("f2_b_neuron_hold",  {31'd0, neu_b}, 1);
        for (int w = 4; w < 7; w++) run_window(w);
        check_frame("f2", c_BAL_NEG4, 0, 255, 1);
        chk("f2_b_fullscale_pattern", bmis[0], 0);

        // Three positive weight-60 pixels on A.
        pix_a = 7'b0000111;
        pix_b = 7'b0101010;
        ea = '{316, 316, 316, 256, 256, 256, 256};
        eb = '{256, 511, 256, 252, 256, 252, 256};
        run_frame();
        check_frame("f3", 180, 1, 247, 1);

        // Reset partway through window 2, then the same frame as f2 must reproduce.
        pix_a = 7'b0001000;
        pix_b = 7'b0000001;
        run_window(0);
        run_window(1);
        repeat (100) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_a_balance",   {21'd0, bal_a}, 0);
        chk("mid_rst_a_neuron",    {31'd0, neu_a}, 0);
        chk("mid_rst_b_balance",   {21'd0, bal_b}, 0);
        chk("mid_rst_b_neuron",    {31'd0, neu_b}, 0);
        chk("mid_rst_b_pixel_out", {31'd0, po_b},  0);
        chk("mid_rst_a_reset_out", {31'd0, ro_a},  0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ea = '{256, 256, 256, 252, 256, 256, 256};
        eb = '{511, 256, 256, 256, 256, 256, 256};
        run_frame();
        check_frame("f4", c_BAL_NEG4, 0, 255, 1);
        chk("f4_b_fullscale_pattern", bmis[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pixel_weight_network.md
# pixel_weight_network

Single-neuron pulse-rate network that scores a HEIGHT-pixel binary input against a signed weight vector. It steps through the pixels one per fixed-length window and generates a baseline pulse train in each window. Each active pixel adds pulses to the train or removes pulses from it, in proportion to its weight. A frame accumulator turns the net pulse surplus into a balance value and a binary neuron decision. The block is composed of a stimulus generator, two rate dividers (negative and positive paths), a one-cycle delay and an output accumulator.

## Interface
- WIDTH, 8, weight magnitude bits; window length = 2^(WIDTH+1) cycles.
- HEIGHT, 7, number of pixels/windows per frame.
- NUM_POS_WEIGHTS, 3, informational only; has no effect on behaviour.
- WEIGHTS, {60,60,60,260,260,260,260}, array [0:HEIGHT-1] of WIDTH+1-bit words. Bit WIDTH = sign (1 = negative). Bits WIDTH-1:0 = magnitude w.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pixels  in  HEIGHT  binary pixel inputs; bit i selects WEIGHTS[i].
- neuron_out  out  1  frame decision.
- balance_out  out  B = clog2(HEIGHT*(2^WIDTH-1)+1)  frame balance.
- pixel_out_out  out  1  combined pulse stream (debug).
- reset_out  out  1  low during the window-clear cycle (debug).

## Operation
- cnt: 0..2^(WIDTH+1)-1, wraps. idx: 0..HEIGHT-1; increments when cnt wraps, and wraps from HEIGHT-1 to 0.
- reset_circuit = (cnt != 0). While low:
  - the stimulus is cleared;
  - both dividers are cleared, with accumulator preset to 2^WIDTH-1;
  - the delay register is cleared;
  - pixel_out is forced to 0.
- stim = 1 on odd cnt, giving 2^WIDTH pulses per window.
- Sign is taken from WEIGHTS[idx][WIDTH] of the current idx.
- Divider:
  - On each stim cycle where pixels[idx]=1 and the path is selected, acc <= (acc + w) mod 2^WIDTH.
  - carry = (acc + w >= 2^WIDTH), combinational in that cycle.
  - Exactly w carries occur within pulses 1..2^WIDTH-1.
- Negative path: pixel_out = stim & !carry_neg. This removes w pulses.
- Positive path: carry_pos is delayed one cycle and ORed in, landing on even cnt. This adds w pulses, all before cnt wraps.
- pixel_out = reset_circuit & ((stim & !carry_neg) | carry_pos_d).
- Output accumulator:
  - Counts pixel_out pulses per window (n, up to 2^(WIDTH+1)-1).
  - On the next cnt==0 cycle, adds n − 2^WIDTH to a signed frame accumulator acc_f.
  - An inactive pixel contributes 0.
- Frame end is the commit of window HEIGHT-1:
  - neuron_out <= (acc_f_final > 0);
  - balance_out <= acc_f_final (see Configuration);
  - acc_f <= 0.
- Outputs hold between frame ends.

## Timing
- Reset values: cnt=0, idx=0, acc_f=0, neuron_out=0, balance_out=0. reset_out=0 and pixel_out_out=0, since cnt=0.
- Window length is 2^(WIDTH+1) cycles (512 at default). Frame length is HEIGHT windows (3584 cycles at default).
- The first cycle after reset release is a clear cycle.
- neuron_out and balance_out update on the first cycle of the window following window HEIGHT-1. This is one cycle after the last pulse opportunity.
- Reset asserted mid-frame discards all partial counts; the frame restarts at idx 0.
- pixels is sampled every cycle. A change mid-window affects only the remaining pulses of that window.
- w=0: no carries, so the pixel is neutral.

## Configuration
- BALANCE_CLAMP_EN:
  - Defined: balance_out = max(acc_f_final, 0), saturated at HEIGHT*(2^WIDTH-1).
  - Undefined: balance_out = low B bits of acc_f_final in two's complement.
- neuron_out is identical in both cases.

## Test plan
- All defaults, pixels=0 for one frame -> 256 pulses every window; balance_out=0, neuron_out=0.
- WEIGHTS={255,255,60,260,260,260,260}, pixels=7'b0101010 -> window 1 has 511 pulses; windows 3 and 5 have 252; balance_out=247, neuron_out=1.
- Only pixels[3]=1, weight 260 -> window 3 has 252 pulses, acc_f=-4, neuron_out=0. balance_out=0 with BALANCE_CLAMP_EN, 2044 without.
- Weight 255, positive, pixel on -> pixel_out_out high on every cycle cnt 1..511; low at cnt 0.
- Assert rst mid-window 2, release -> outputs 0; next frame reproduces the clean-run results exactly.
- reset_out check -> low exactly once per 512 cycles, in the same cycle as each idx change.
